// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit and its HI/LO pair.
package muldiv_pkg;

    // Operation encodings as presented on the op port; 6 and 7 are reserved.
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

    // Number of shift-add passes needed to consume the whole multiplier.
    function automatic int mul_iters(input int data_width, input int mul_bits);
        return data_width / mul_bits;
    endfunction

endpackage

// File: rtl/div_iter_core.sv
// One restoring-division step: shift in the next dividend bit, try to subtract
// the divisor, keep the difference only when it did not go negative.
module div_iter_core
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_in,
    input  logic [DATA_WIDTH-1:0] quot_in,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic [DATA_WIDTH-1:0] quot_out
);

    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;
    logic                q_bit;

    // Trial subtraction; the extra top bit of diff is the borrow.
    always_comb begin
        shifted = {rem_in, quot_in[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[DATA_WIDTH]) begin
            rem_out = diff[DATA_WIDTH-1:0];
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted[DATA_WIDTH-1:0];
            q_bit   = 1'b0;
        end
        quot_out = {quot_in[DATA_WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Signed operations run on magnitudes and fix the signs up in a final cycle.
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_BITS   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] srcA,
    input  logic [DATA_WIDTH-1:0] srcB,
    input  logic                  cancel,
    output logic                  busy,
    output logic                  done,
    output logic                  dbz,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);

    localparam int DW = DATA_WIDTH;
    localparam int MB = MUL_BITS;
    localparam int NM = mul_iters(DATA_WIDTH, MUL_BITS);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(NM - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DATA_WIDTH - 1);

    state_e state, next_state;

    logic [CW-1:0]   count;
    logic [2*DW-1:0] acc;
    logic [DW-1:0]   mcand;
    logic [DW-1:0]   mplier;
    logic            neg_res;
    logic            neg_rem;
    logic            is_div;
    logic            dbz_pend;
    logic [DW-1:0]   hi_q;
    logic [DW-1:0]   lo_q;
    logic            done_q;
    logic            dbz_q;

    logic            accept;
    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [DW-1:0]   a_mag;
    logic [DW-1:0]   b_mag;
    logic [DW+MB-1:0] partial;
    logic [DW+MB-1:0] upper_sum;
    logic [2*DW-1:0] mul_next;
    logic [DW-1:0]   acc_hi;
    logic [DW-1:0]   acc_lo;
    logic [DW-1:0]   rem_next;
    logic [DW-1:0]   quot_next;
    logic [2*DW-1:0] prod_fix;
    logic [DW-1:0]   q_fix;
    logic [DW-1:0]   r_fix;

    assign accept    = (state == IDLE) && start && !cancel;
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = signed_op && srcA[DW-1];
    assign b_neg     = signed_op && srcB[DW-1];
    assign a_mag     = a_neg ? -srcA : srcA;
    assign b_mag     = b_neg ? -srcB : srcB;

    assign acc_hi = acc[2*DW-1:DW];
    assign acc_lo = acc[DW-1:0];

    // Shift-add step: add mcand times the next multiplier digit to the upper half,
    // then shift the whole accumulator right by one digit.
    assign partial   = (DW+MB)'(mcand) * (DW+MB)'(mplier[MB-1:0]);
    assign upper_sum = {{MB{1'b0}}, acc_hi} + partial;
    assign mul_next  = {upper_sum, acc[DW-1:MB]};

    div_iter_core #(.DATA_WIDTH(DW)) u_div_iter (
        .rem_in   (acc_hi),
        .quot_in  (acc_lo),
        .divisor  (mcand),
        .rem_out  (rem_next),
        .quot_out (quot_next)
    );

    assign prod_fix = neg_res ? -acc : acc;
    assign q_fix    = neg_res ? -acc_lo : acc_lo;
    assign r_fix    = neg_rem ? -acc_hi : acc_hi;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state selection; cancel only aborts the iterating states.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MULT || op == OP_MULTU)
                        next_state = MUL;
                    else if (op == OP_DIV || op == OP_DIVU)
                        next_state = (srcB == '0) ? FIX : DIV;
                end
            end
            MUL:     if (cancel) next_state = IDLE;
                     else if (count == MUL_LAST) next_state = FIX;
            DIV:     if (cancel) next_state = IDLE;
                     else if (count == DIV_LAST) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, iteration work registers and the HI/LO commit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count    <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            is_div   <= 1'b0;
            dbz_pend <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MTHI: begin
                                hi_q   <= srcA;
                                done_q <= 1'b1;
                                dbz_q  <= 1'b0;
                            end
                            OP_MTLO: begin
                                lo_q   <= srcA;
                                done_q <= 1'b1;
                                dbz_q  <= 1'b0;
                            end
                            OP_MULT, OP_MULTU: begin
                                acc      <= '0;
                                mcand    <= a_mag;
                                mplier   <= b_mag;
                                neg_res  <= a_neg ^ b_neg;
                                neg_rem  <= 1'b0;
                                is_div   <= 1'b0;
                                dbz_pend <= 1'b0;
                                count    <= '0;
                                dbz_q    <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc      <= {{DW{1'b0}}, (srcB == '0) ? srcA : a_mag};
                                mcand    <= b_mag;
                                neg_res  <= a_neg ^ b_neg;
                                neg_rem  <= a_neg;
                                is_div   <= 1'b1;
                                dbz_pend <= (srcB == '0);
                                count    <= '0;
                                dbz_q    <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (!cancel) begin
                        acc    <= mul_next;
                        mplier <= mplier >> MB;
                        count  <= count + CW'(1);
                    end
                end
                DIV: begin
                    if (!cancel) begin
                        acc   <= {rem_next, quot_next};
                        count <= count + CW'(1);
                    end
                end
                FIX: begin
                    done_q <= 1'b1;
                    if (dbz_pend) begin
                        hi_q  <= acc_lo;
                        lo_q  <= '1;
                        dbz_q <= 1'b1;
                    end else if (is_div) begin
                        lo_q <= q_fix;
                        hi_q <= r_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = done_q;
    assign dbz    = dbz_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule
